myo_spi_responder: RTL and testbench

- SPI slave (responder) for the myocontrol muscle-bus protocol. It sits on the motor-board FPGA at the far end of the myocontrol SPI master's miso/mosi/sck/ss_n lines.
- It receives fixed-length command frames of 16-bit words from the master and deframes them into a word stream.
- It simultaneously shifts out a status frame that is snapshotted at frame start.
- All SPI inputs are oversampled in the system clock domain. No logic is clocked by sck.

---
 rtl/myo_spi_responder.sv | 213 +++++++++++++++++++++
 tb/tb_myo_spi_responder.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/myo_spi_responder.sv
// SPI responder (CPOL=0, CPHA=0) for the myocontrol muscle bus: deframes 16-bit command words, shifts out a snapshotted status frame.
// Latency: rx_valid 4 clk after the pad sck rise of a word's last bit; miso updates 3 clk after a pad sck fall.
// Backpressure: none; the SPI master owns the pace, so clk must run at least 8x sck.
module myo_spi_responder #(
  parameter int WORD_W    = 16,
  parameter int NUM_WORDS = 6,
  parameter int IDX_W     = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          sck,
  input  logic                          mosi,
  input  logic                          ss_n,
  output logic                          miso,
  output logic                          miso_oe,
  input  logic [NUM_WORDS*WORD_W-1:0]   tx_frame,
  output logic                          tx_latched,
  output logic [WORD_W-1:0]             rx_word,
  output logic [IDX_W-1:0]              rx_index,
  output logic                          rx_valid,
  output logic                          frame_done,
  output logic                          frame_error
);

  localparam int FRAME_W = NUM_WORDS * WORD_W;
  localparam int BCNT_W  = $clog2(WORD_W + 1);
  localparam logic [BCNT_W-1:0] BITS_PER_WORD   = BCNT_W'(WORD_W);
  localparam logic [IDX_W-1:0]  WORDS_PER_FRAME = IDX_W'(NUM_WORDS);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_END    = 2'd2
  } state_t;

  // Synchronizer chains: [0] and [1] are the 2-FF synchronizer, [2] is the edge-detect history.
  // They reset to 0 so that ss_n held low through reset release never looks like a falling edge.
  logic [2:0] sck_sync_q, sck_sync_d;
  logic [2:0] mosi_sync_q, mosi_sync_d;
  logic [2:0] ss_sync_q, ss_sync_d;

  state_t               state_q, state_d;
  logic [FRAME_W-1:0]   tx_shift_q, tx_shift_d;
  logic [WORD_W-1:0]    rx_shift_q, rx_shift_d;
  logic [BCNT_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [IDX_W-1:0]     word_cnt_q, word_cnt_d;
  logic                 overrun_q, overrun_d;
  logic                 pending_q, pending_d;
  logic                 miso_q, miso_d;
  logic                 miso_oe_q, miso_oe_d;
  logic [WORD_W-1:0]    rx_word_q, rx_word_d;
  logic [IDX_W-1:0]     rx_index_q, rx_index_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 tx_latched_q, tx_latched_d;
  logic                 frame_done_q, frame_done_d;
  logic                 frame_error_q, frame_error_d;

  logic sck_rise, sck_fall, ss_fall, ss_rise;
  logic ss_s, mosi_s;

  // Shift the pad inputs through their synchronizer and history stages.
  always_comb begin
    sck_sync_d  = {sck_sync_q[1:0], sck};
    mosi_sync_d = {mosi_sync_q[1:0], mosi};
    ss_sync_d   = {ss_sync_q[1:0], ss_n};
  end

  // Edge strobes from the synchronized value against its history.
  // mosi is taken from its history stage: the value that was present while sck was still seen low.
  always_comb begin
    sck_rise = sck_sync_q[1] & ~sck_sync_q[2];
    sck_fall = ~sck_sync_q[1] & sck_sync_q[2];
    ss_fall  = ~ss_sync_q[1] & ss_sync_q[2];
    ss_rise  = ss_sync_q[1] & ~ss_sync_q[2];
    ss_s     = ss_sync_q[1];
    mosi_s   = mosi_sync_q[2];
  end

  // Frame FSM: next-state and next-output computation.
  always_comb begin
    state_d       = state_q;
    tx_shift_d    = tx_shift_q;
    rx_shift_d    = rx_shift_q;
    bit_cnt_d     = bit_cnt_q;
    word_cnt_d    = word_cnt_q;
    overrun_d     = overrun_q;
    pending_d     = pending_q;
    miso_d        = miso_q;
    miso_oe_d     = miso_oe_q;
    rx_word_d     = rx_word_q;
    rx_index_d    = rx_index_q;
    rx_valid_d    = 1'b0;
    tx_latched_d  = 1'b0;
    frame_done_d  = 1'b0;
    frame_error_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        pending_d = 1'b0;
        // A start seen during END is taken here if ss_n is still low.
        if (ss_fall || (pending_q && !ss_s)) begin
          state_d      = ST_ACTIVE;
          miso_d       = tx_frame[FRAME_W-1];
          tx_shift_d   = tx_frame << 1;
          miso_oe_d    = 1'b1;
          tx_latched_d = 1'b1;
          bit_cnt_d    = '0;
          word_cnt_d   = '0;
          overrun_d    = 1'b0;
          rx_shift_d   = '0;
        end
      end

      ST_ACTIVE: begin
        // Word completion is settled even if ss_n rises in the same cycle,
        // so END sees counters that already account for the last word.
        if (bit_cnt_q == BITS_PER_WORD) begin
          bit_cnt_d = '0;
          if (word_cnt_q < WORDS_PER_FRAME) begin
            rx_word_d  = rx_shift_q;
            rx_index_d = word_cnt_q;
            rx_valid_d = 1'b1;
            word_cnt_d = word_cnt_q + 1'b1;
          end else begin
            overrun_d = 1'b1;
          end
        end

        if (ss_rise) begin
          state_d   = ST_END;
          miso_oe_d = 1'b0;
          miso_d    = 1'b0;
        end else if (sck_rise) begin
          rx_shift_d = {rx_shift_q[WORD_W-2:0], mosi_s};
          bit_cnt_d  = bit_cnt_q + 1'b1;
        end else if (sck_fall) begin
          // Zeros shift in behind the snapshot, so overrun words read as 0.
          miso_d     = tx_shift_q[FRAME_W-1];
          tx_shift_d = tx_shift_q << 1;
        end
      end

      ST_END: begin
        state_d = ST_IDLE;
        if ((word_cnt_q == WORDS_PER_FRAME) && (bit_cnt_q == '0) && !overrun_q) begin
          frame_done_d = 1'b1;
        end else begin
          frame_error_d = 1'b1;
        end
        if (ss_fall) begin
          pending_d = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // All state and registered outputs; reset aborts any frame without a done/error pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sck_sync_q    <= '0;
      mosi_sync_q   <= '0;
      ss_sync_q     <= '0;
      state_q       <= ST_IDLE;
      tx_shift_q    <= '0;
      rx_shift_q    <= '0;
      bit_cnt_q     <= '0;
      word_cnt_q    <= '0;
      overrun_q     <= 1'b0;
      pending_q     <= 1'b0;
      miso_q        <= 1'b0;
      miso_oe_q     <= 1'b0;
      rx_word_q     <= '0;
      rx_index_q    <= '0;
      rx_valid_q    <= 1'b0;
      tx_latched_q  <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      sck_sync_q    <= sck_sync_d;
      mosi_sync_q   <= mosi_sync_d;
      ss_sync_q     <= ss_sync_d;
      state_q       <= state_d;
      tx_shift_q    <= tx_shift_d;
      rx_shift_q    <= rx_shift_d;
      bit_cnt_q     <= bit_cnt_d;
      word_cnt_q    <= word_cnt_d;
      overrun_q     <= overrun_d;
      pending_q     <= pending_d;
      miso_q        <= miso_d;
      miso_oe_q     <= miso_oe_d;
      rx_word_q     <= rx_word_d;
      rx_index_q    <= rx_index_d;
      rx_valid_q    <= rx_valid_d;
      tx_latched_q  <= tx_latched_d;
      frame_done_q  <= frame_done_d;
      frame_error_q <= frame_error_d;
    end
  end

  assign miso        = miso_q;
  assign miso_oe     = miso_oe_q;
  assign rx_word     = rx_word_q;
  assign rx_index    = rx_index_q;
  assign rx_valid    = rx_valid_q;
  assign tx_latched  = tx_latched_q;
  assign frame_done  = frame_done_q;
  assign frame_error = frame_error_q;

endmodule

// File: tb/tb_myo_spi_responder.sv
// Bench for myo_spi_responder: table of frames plus reset, back-to-back and reset-release sequences.
// sck runs at clk/10; expected rx words go to a scoreboard queue and are popped on rx_valid.
// Outputs are sampled on the falling clk edge, inputs driven 1 ns after the rising edge.
module tb_myo_spi_responder;
  localparam int WORD_W    = 16;
  localparam int NUM_WORDS = 6;
  localparam int IDX_W     = 3;
  localparam int HALF      = 5;

  logic                        clk = 1'b0;
  logic                        reset;
  logic                        sck;
  logic                        mosi;
  logic                        ss_n;
  logic                        miso;
  logic                        miso_oe;
  logic [NUM_WORDS*WORD_W-1:0] tx_frame;
  logic                        tx_latched;
  logic [WORD_W-1:0]           rx_word;
  logic [IDX_W-1:0]            rx_index;
  logic                        rx_valid;
  logic                        frame_done;
  logic                        frame_error;

  myo_spi_responder #(.WORD_W(WORD_W), .NUM_WORDS(NUM_WORDS), .IDX_W(IDX_W)) dut (
    .clk(clk), .reset(reset), .sck(sck), .mosi(mosi), .ss_n(ss_n),
    .miso(miso), .miso_oe(miso_oe), .tx_frame(tx_frame), .tx_latched(tx_latched),
    .rx_word(rx_word), .rx_index(rx_index), .rx_valid(rx_valid),
    .frame_done(frame_done), .frame_error(frame_error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [IDX_W-1:0]  idx;
    logic [WORD_W-1:0] word;
  } exp_t;

  typedef struct {
    string                       name;
    int                          nwords;
    int                          extra;
    logic [NUM_WORDS*WORD_W-1:0] txf;
    bit                          rand_words;
    bit                          snap;
    int                          exp_rx;
    int                          exp_done;
    int                          exp_err;
  } vec_t;

  exp_t              sbq[$];
  logic [WORD_W-1:0] mosi_w[0:7];
  int errors = 0;
  int checks = 0;
  int n_rx = 0, n_done = 0, n_err = 0, n_lat = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: sample outputs on the falling edge, feed the scoreboard, return just after the rising edge.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (rx_valid) begin
      n_rx++;
      if (sbq.size() == 0) begin
        chk("rx_unexpected", {13'd0, rx_index, rx_word}, 32'hFFFF_FFFF);
      end else begin
        e = sbq.pop_front();
        chk("rx_word_index", {13'd0, rx_index, rx_word}, {13'd0, e.idx, e.word});
      end
    end
    if (frame_done) n_done++;
    if (frame_error) n_err++;
    if (tx_latched) n_lat++;
    if (frame_done && frame_error) chk("done_and_error", 32'd1, 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Master side of one word: mosi changes with the falling edge, miso captured at the rising edge.
  task automatic send_word(input logic [WORD_W-1:0] w, input int nbits, output logic [WORD_W-1:0] cap);
    cap = '0;
    for (int b = 0; b < nbits; b++) begin
      mosi = w[WORD_W-1-b];
      tick_n(HALF);
      cap[WORD_W-1-b] = miso;
      if (b == 0) chk("miso_oe_active", {31'd0, miso_oe}, 32'd1);
      sck = 1'b1;
      tick_n(HALF);
      sck = 1'b0;
    end
  endtask

  task automatic frame_begin();
    ss_n = 1'b0;
    tick_n(6);
  endtask

  task automatic frame_end();
    tick_n(3);
    ss_n = 1'b1;
    tick_n(10);
    chk("miso_oe_idle", {31'd0, miso_oe}, 32'd0);
  endtask

  task automatic frame_words(input int nwords, input int extra, input logic [NUM_WORDS*WORD_W-1:0] txf);
    logic [WORD_W-1:0] cap;
    logic [WORD_W-1:0] exp_miso;
    for (int w = 0; w < nwords; w++) begin
      if (w < NUM_WORDS) sbq.push_back({IDX_W'(w), mosi_w[w]});
      send_word(mosi_w[w], WORD_W, cap);
      exp_miso = (w < NUM_WORDS) ? txf[(NUM_WORDS-w)*WORD_W-1 -: WORD_W] : '0;
      chk($sformatf("miso_word%0d", w), {16'd0, cap}, {16'd0, exp_miso});
    end
    if (extra > 0) send_word(mosi_w[nwords], extra, cap);
  endtask

  task automatic run_vec(input vec_t v);
    int rx0, d0, e0, l0;
    rx0 = n_rx; d0 = n_done; e0 = n_err; l0 = n_lat;
    tx_frame = v.txf;
    frame_begin();
    if (v.snap) tx_frame = {NUM_WORDS{16'hBEEF}};
    frame_words(v.nwords, v.extra, v.txf);
    frame_end();
    chk({v.name, "_rx_count"}, n_rx - rx0, v.exp_rx);
    chk({v.name, "_done"}, n_done - d0, v.exp_done);
    chk({v.name, "_error"}, n_err - e0, v.exp_err);
    chk({v.name, "_latched"}, n_lat - l0, 1);
    chk({v.name, "_sb_empty"}, sbq.size(), 0);
  endtask

  task automatic fill_random();
    for (int i = 0; i < 8; i++) mosi_w[i] = WORD_W'($urandom_range(0, 65535));
  endtask

  task automatic fill_nominal();
    mosi_w[0] = 16'hA001; mosi_w[1] = 16'h0002; mosi_w[2] = 16'h0003;
    mosi_w[3] = 16'h0004; mosi_w[4] = 16'h0005; mosi_w[5] = 16'hFFFF;
    mosi_w[6] = 16'h1234; mosi_w[7] = 16'h5678;
  endtask

  vec_t vecs[6];
  localparam logic [NUM_WORDS*WORD_W-1:0] TX_NOM = 96'h1111_2222_3333_4444_5555_6666;
  localparam logic [NUM_WORDS*WORD_W-1:0] TX_ALT = 96'h0123_4567_89AB_CDEF_FEDC_BA98;

  initial begin
    int rx0, d0, e0, l0;
    vecs[0] = '{"nominal",  6, 0, TX_NOM, 1'b0, 1'b0, 6, 1, 0};
    vecs[1] = '{"snapshot", 6, 0, TX_NOM, 1'b0, 1'b1, 6, 1, 0};
    vecs[2] = '{"short",    3, 5, TX_ALT, 1'b1, 1'b0, 3, 0, 1};
    vecs[3] = '{"overrun",  7, 0, TX_ALT, 1'b1, 1'b0, 6, 0, 1};
    vecs[4] = '{"empty",    0, 0, TX_ALT, 1'b1, 1'b0, 0, 0, 1};
    vecs[5] = '{"random",   6, 0, TX_ALT, 1'b1, 1'b0, 6, 1, 0};

    reset = 1'b1; sck = 1'b0; mosi = 1'b0; ss_n = 1'b1; tx_frame = TX_NOM;
    #1;
    chk("reset_outputs", {7'd0, miso, miso_oe, tx_latched, rx_valid, frame_done, frame_error, rx_index, rx_word}, 32'd0);
    tick_n(3);
    reset = 1'b0;
    tick_n(5);
    chk("idle_outputs", {7'd0, miso, miso_oe, tx_latched, rx_valid, frame_done, frame_error, rx_index, rx_word}, 32'd0);

    for (int i = 0; i < 6; i++) begin
      if (vecs[i].rand_words) fill_random();
      else fill_nominal();
      run_vec(vecs[i]);
    end

    // Reset after word 2 of a frame, then a clean frame must start at index 0.
    fill_random();
    tx_frame = TX_ALT;
    d0 = n_done; e0 = n_err;
    frame_begin();
    frame_words(2, 0, TX_ALT);
    tick_n(2);
    reset = 1'b1;
    #1;
    chk("midframe_reset_outputs", {7'd0, miso, miso_oe, tx_latched, rx_valid, frame_done, frame_error, rx_index, rx_word}, 32'd0);
    tick();
    ss_n = 1'b1;
    tick_n(3);
    reset = 1'b0;
    tick_n(5);
    chk("midframe_reset_no_done", n_done - d0, 0);
    chk("midframe_reset_no_error", n_err - e0, 0);
    fill_nominal();
    run_vec(vecs[0]);

    // Back-to-back frames with ss_n high for 2 clk between them.
    rx0 = n_rx; d0 = n_done; e0 = n_err; l0 = n_lat;
    fill_random();
    tx_frame = TX_NOM;
    frame_begin();
    frame_words(6, 0, TX_NOM);
    tick_n(3);
    ss_n = 1'b1;
    tick_n(2);
    tx_frame = TX_ALT;
    fill_random();
    ss_n = 1'b0;
    tick_n(6);
    frame_words(6, 0, TX_ALT);
    frame_end();
    chk("b2b_rx_count", n_rx - rx0, 12);
    chk("b2b_done", n_done - d0, 2);
    chk("b2b_error", n_err - e0, 0);
    chk("b2b_latched", n_lat - l0, 2);

    // ss_n held low through reset release must not start a frame.
    reset = 1'b1; ss_n = 1'b0;
    tick_n(3);
    l0 = n_lat;
    reset = 1'b0;
    tick_n(12);
    chk("ss_low_at_reset_no_latch", n_lat - l0, 0);
    chk("ss_low_at_reset_oe", {31'd0, miso_oe}, 32'd0);
    ss_n = 1'b1;
    tick_n(6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
